local_input_buffer: RTL and testbench

Router local-port input buffer sitting directly downstream of a PE traffic injector. It accepts 32-bit packets over the Req/Gnt/Full handshake and stores them in a DEPTH-entry circular FIFO. It forwards them in order to the router's local input stage over an identical Req/Gnt/Full handshake, and keeps wrap-around accept/forward counters for the simulation logs.

---
 rtl/local_input_buffer.sv | 112 +++++++++++
 tb/tb_local_input_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/local_input_buffer.sv
// Local-port input buffer: a circular FIFO between the PE injector and the router
// local input stage, with Req/Gnt/Full handshakes on both sides and wrap-around counters.
module local_input_buffer #(
   parameter int dataWidth = 32,
   parameter int DEPTH     = 4,
   parameter int ptrWidth  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ReqUpStr,
   input  logic [dataWidth-1:0] PacketIn,
   output logic                 GntUpStr,
   output logic                 UpStrFull,
   output logic                 ReqDnStr,
   output logic [dataWidth-1:0] PacketOut,
   input  logic                 GntDnStr,
   input  logic                 DnStrFull,
   output logic [ptrWidth:0]    Occupancy,
   output logic [15:0]          PktInCount,
   output logic [15:0]          PktOutCount
);

   typedef enum logic {OUT_IDLE, OUT_WAIT} state_t;

   localparam logic [ptrWidth:0] FULL_CNT = (ptrWidth+1)'(DEPTH);

   logic [DEPTH-1:0][dataWidth-1:0] mem_q;
   logic [ptrWidth-1:0]             wp_q, wp_d, rp_q, rp_d;
   logic [ptrWidth:0]               occ_q, occ_d;
   logic                            gnt_q, gnt_d, req_q, req_d;
   logic [dataWidth-1:0]            pkt_q, pkt_d;
   logic [15:0]                     incnt_q, incnt_d, outcnt_q, outcnt_d;
   state_t                          state_q, state_d;
   logic                            accept, pop;

   // Full is taken from the pre-edge count, so a same-edge pop never enables an accept.
   assign UpStrFull   = (occ_q == FULL_CNT);
   assign accept      = ReqUpStr && !UpStrFull && !gnt_q;
   assign GntUpStr    = gnt_q;
   assign ReqDnStr    = req_q;
   assign PacketOut   = pkt_q;
   assign Occupancy   = occ_q;
   assign PktInCount  = incnt_q;
   assign PktOutCount = outcnt_q;

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      pkt_d    = pkt_q;
      rp_d     = rp_q;
      outcnt_d = outcnt_q;
      pop      = 1'b0;
      case (state_q)
         OUT_IDLE: begin
            if (occ_q != '0 && !DnStrFull) begin
               pop     = 1'b1;
               pkt_d   = mem_q[rp_q];
               rp_d    = rp_q + ptrWidth'(1);
               req_d   = 1'b1;
               state_d = OUT_WAIT;
            end
         end
         OUT_WAIT: begin
            if (GntDnStr) begin
               req_d    = 1'b0;
               outcnt_d = outcnt_q + 16'd1;
               state_d  = OUT_IDLE;
            end
         end
         default: state_d = OUT_IDLE;
      endcase
   end

   always_comb begin
      gnt_d   = accept;
      wp_d    = accept ? wp_q + ptrWidth'(1) : wp_q;
      incnt_d = accept ? incnt_q + 16'd1 : incnt_q;
      occ_d   = occ_q;
      if (accept && !pop)      occ_d = occ_q + (ptrWidth+1)'(1);
      else if (!accept && pop) occ_d = occ_q - (ptrWidth+1)'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= OUT_IDLE;
         wp_q     <= '0;
         rp_q     <= '0;
         occ_q    <= '0;
         gnt_q    <= 1'b0;
         req_q    <= 1'b0;
         pkt_q    <= '0;
         incnt_q  <= '0;
         outcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         occ_q    <= occ_d;
         gnt_q    <= gnt_d;
         req_q    <= req_d;
         pkt_q    <= pkt_d;
         incnt_q  <= incnt_d;
         outcnt_q <= outcnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mem_q <= '0;
      else if (accept) mem_q[wp_q] <= PacketIn;
   end

endmodule

// File: tb/tb_local_input_buffer.sv
// Directed bench for local_input_buffer: reset, cut-through, full/drain boundary,
// long random-gap stream with scoreboard, async mid-operation reset, spurious grant.
module tb_local_input_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ReqUpStr, GntDnStr, DnStrFull;
   logic [31:0] PacketIn, PacketOut;
   logic        GntUpStr, UpStrFull, ReqDnStr;
   logic [2:0]  Occupancy;
   logic [15:0] PktInCount, PktOutCount;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];
   int maxocc = 0;

   local_input_buffer #(.dataWidth(32), .DEPTH(4), .ptrWidth(2)) dut (
      .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
      .GntUpStr(GntUpStr), .UpStrFull(UpStrFull), .ReqDnStr(ReqDnStr),
      .PacketOut(PacketOut), .GntDnStr(GntDnStr), .DnStrFull(DnStrFull),
      .Occupancy(Occupancy), .PktInCount(PktInCount), .PktOutCount(PktOutCount)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (int'(Occupancy) > maxocc) maxocc = int'(Occupancy);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mkpkt(input logic [3:0] xd, input logic [3:0] yd,
                                         input logic [9:0] id);
      return {xd, yd, 4'h0, 4'h0, id, 6'h00};
   endfunction

   // Hold Req until granted (bounded), then drop it.
   task automatic inject(input logic [31:0] p);
      int n = 0;
      ReqUpStr = 1'b1;
      PacketIn = p;
      do begin tick(); n++; end while (!GntUpStr && n < 300);
      chk("inj_gnt", {31'd0, GntUpStr}, 32'd1);
      if (GntUpStr) sb.push_back(p);
      ReqUpStr = 1'b0;
   endtask

   // Wait for ReqDnStr (bounded), capture the packet, grant after dly cycles.
   task automatic recv(input int dly, output logic [31:0] p, output logic ok);
      int n = 0;
      while (!ReqDnStr && n < 300) begin tick(); n++; end
      ok = ReqDnStr;
      p  = PacketOut;
      if (!ok) begin
         chk("recv_req", 32'd0, 32'd1);
         return;
      end
      repeat (dly) tick();
      GntDnStr = 1'b1;
      tick();
      GntDnStr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      sb.delete();
      tick();
   endtask

   initial begin
      logic [31:0] p, e;
      logic ok, seen;
      reset = 1'b1; ReqUpStr = 1'b0; PacketIn = '0; GntDnStr = 1'b0; DnStrFull = 1'b0;
      #1;
      do_reset();
      chk("rst_gnt", {31'd0, GntUpStr}, 32'd0);
      chk("rst_req", {31'd0, ReqDnStr}, 32'd0);
      chk("rst_pkt", PacketOut, 32'd0);
      chk("rst_occ", {29'd0, Occupancy}, 32'd0);
      chk("rst_full", {31'd0, UpStrFull}, 32'd0);
      chk("rst_cnt", {PktInCount, PktOutCount}, 32'd0);

      // single packet cut-through: Gnt one cycle, ReqDnStr one edge later
      p = mkpkt(4'd4, 4'd2, 10'd1);
      ReqUpStr = 1'b1; PacketIn = p;
      tick();
      chk("s_gnt", {31'd0, GntUpStr}, 32'd1);
      chk("s_occ1", {29'd0, Occupancy}, 32'd1);
      chk("s_req0", {31'd0, ReqDnStr}, 32'd0);
      ReqUpStr = 1'b0;
      tick();
      chk("s_gnt_drop", {31'd0, GntUpStr}, 32'd0);
      chk("s_req1", {31'd0, ReqDnStr}, 32'd1);
      chk("s_pkt", PacketOut, p);
      chk("s_occ0", {29'd0, Occupancy}, 32'd0);
      GntDnStr = 1'b1;
      tick();
      GntDnStr = 1'b0;
      chk("s_req_drop", {31'd0, ReqDnStr}, 32'd0);
      chk("s_incnt", {16'd0, PktInCount}, 32'd1);
      chk("s_outcnt", {16'd0, PktOutCount}, 32'd1);

      // fill to DEPTH with downstream full
      DnStrFull = 1'b1;
      sb.delete();
      maxocc = 0;
      for (int i = 1; i <= 4; i++) inject(mkpkt(4'd1, 4'd1, 10'(i)));
      tick();
      chk("f_occ", {29'd0, Occupancy}, 32'd4);
      chk("f_full", {31'd0, UpStrFull}, 32'd1);
      chk("f_req", {31'd0, ReqDnStr}, 32'd0);
      ReqUpStr = 1'b1; PacketIn = mkpkt(4'd1, 4'd1, 10'd5);
      seen = 1'b0;
      repeat (10) begin tick(); if (GntUpStr) seen = 1'b1; end
      chk("f_nogrant", {31'd0, seen}, 32'd0);

      // drain: pop at edge a blocks the same-edge accept; grant follows at a+1
      DnStrFull = 1'b0;
      tick();
      chk("d_occ3", {29'd0, Occupancy}, 32'd3);
      chk("d_gnt0", {31'd0, GntUpStr}, 32'd0);
      chk("d_req", {31'd0, ReqDnStr}, 32'd1);
      chk("d_pkt1", PacketOut, mkpkt(4'd1, 4'd1, 10'd1));
      tick();
      chk("d_gnt1", {31'd0, GntUpStr}, 32'd1);
      chk("d_occ4", {29'd0, Occupancy}, 32'd4);
      ReqUpStr = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         recv(0, p, ok);
         if (ok) chk("d_order", p, mkpkt(4'd1, 4'd1, 10'(i)));
      end
      tick();
      chk("d_maxocc", maxocc, 32'd4);
      chk("d_occ_end", {29'd0, Occupancy}, 32'd0);
      chk("d_cnts", {PktInCount, PktOutCount}, {16'd6, 16'd6});

      // spurious grant in OUT_IDLE with empty FIFO
      GntDnStr = 1'b1;
      tick();
      GntDnStr = 1'b0;
      tick();
      chk("sp_outcnt", {16'd0, PktOutCount}, 32'd6);
      chk("sp_req", {31'd0, ReqDnStr}, 32'd0);
      chk("sp_occ", {29'd0, Occupancy}, 32'd0);

      // long stream with random gaps and grant delays; pointers wrap many times
      do_reset();
      fork
         begin
            for (int i = 0; i < 1023; i++) begin
               repeat ($urandom_range(0, 15)) tick();
               inject($urandom);
            end
         end
         begin
            for (int i = 0; i < 1023; i++) begin
               recv(int'($urandom_range(0, 7)), p, ok);
               if (!ok) break;
               e = (sb.size() > 0) ? sb.pop_front() : ~p;
               chk("w_order", p, e);
            end
         end
      join
      tick();
      chk("w_incnt", {16'd0, PktInCount}, 32'd1023);
      chk("w_outcnt", {16'd0, PktOutCount}, 32'd1023);
      chk("w_occ", {29'd0, Occupancy}, 32'd0);

      // async reset with 3 stored and one presented downstream
      DnStrFull = 1'b1;
      for (int i = 1; i <= 4; i++) inject(mkpkt(4'd7, 4'd7, 10'(i)));
      DnStrFull = 1'b0;
      tick();
      chk("r_occ3", {29'd0, Occupancy}, 32'd3);
      chk("r_req1", {31'd0, ReqDnStr}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("r_req_async", {31'd0, ReqDnStr}, 32'd0);
      chk("r_occ_async", {29'd0, Occupancy}, 32'd0);
      chk("r_pkt_async", PacketOut, 32'd0);
      tick();
      reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin tick(); if (ReqDnStr || Occupancy != 3'd0) seen = 1'b1; end
      chk("r_no_stale", {31'd0, seen}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
